// File: rtl/video_timing_decoder.sv
// Video timing decoder: recovers x/y from an hs/vs/de stream, measures line
// and frame totals, and declares lock once two consecutive frames agree with
// each other and with the configured active resolution.
module video_timing_decoder #(
    parameter int unsigned HOR_ACTIVE_PIXELS = 640,
    parameter int unsigned VER_ACTIVE_PIXELS = 480,
    parameter int unsigned HOR_SYNC_POLARITY = 0,
    parameter int unsigned VER_SYNC_POLARITY = 0,
    parameter int unsigned MAX_HOR_TOTAL     = 2200,
    parameter int unsigned MAX_VER_TOTAL     = 1125
) (
    input  logic                                     clk_rgb,
    input  logic                                     rst,
    input  logic                                     ce,
    input  logic                                     hs,
    input  logic                                     vs,
    input  logic                                     de,
    output logic [$clog2(HOR_ACTIVE_PIXELS)-1:0]     x,
    output logic [$clog2(VER_ACTIVE_PIXELS)-1:0]     y,
    output logic                                     valid,
    output logic                                     frame_start,
    output logic                                     locked,
    output logic                                     err,
    output logic [$clog2(MAX_HOR_TOTAL+1)-1:0]       h_total,
    output logic [$clog2(MAX_VER_TOTAL+1)-1:0]       v_total
);
    localparam int XW = $clog2(HOR_ACTIVE_PIXELS);
    localparam int YW = $clog2(VER_ACTIVE_PIXELS);
    localparam int HW = $clog2(MAX_HOR_TOTAL + 1);
    localparam int VW = $clog2(MAX_VER_TOTAL + 1);

    localparam logic          HPOL = (HOR_SYNC_POLARITY != 0);
    localparam logic          VPOL = (VER_SYNC_POLARITY != 0);
    localparam logic [HW-1:0] HMAX = HW'(MAX_HOR_TOTAL);
    localparam logic [VW-1:0] VMAX = VW'(MAX_VER_TOTAL);
    localparam logic [HW-1:0] HACT = HW'(HOR_ACTIVE_PIXELS);
    localparam logic [VW-1:0] VACT = VW'(VER_ACTIVE_PIXELS);
    localparam logic [HW-1:0] XMAX = HW'(HOR_ACTIVE_PIXELS - 1);
    localparam logic [VW-1:0] YMAX = VW'(VER_ACTIVE_PIXELS - 1);

    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;
    state_t state;

    // stage 1 and its one-ce-old copy for edge detection
    logic hs1, vs1, de1, hs1_q, vs1_q, de1_q;

    logic [HW-1:0] h_cnt, run_len, last_run, ref_period, ref_run;
    logic [VW-1:0] v_cnt, nruns, ref_height, ref_runs;
    logic          runs_ok, vs_seen, ref_ok;

    logic          hs_ast, vs_ast, de_rise, de_fall;
    logic [HW-1:0] period, cur_period, pos, cur_run;
    logic [VW-1:0] height, nruns_eff, ypos;
    logic          run_bad, x_over, y_over, frame_good, ref_match, violation;

    // Stage-1 event decode; a line closes before the frame on a shared cycle,
    // and a de run starting on a vs assert belongs to the new frame.
    always_comb begin
        hs_ast     = (hs1 == HPOL) && (hs1_q != HPOL);
        vs_ast     = (vs1 == VPOL) && (vs1_q != VPOL);
        de_rise    = de1 && !de1_q;
        de_fall    = !de1 && de1_q;
        period     = (h_cnt == HMAX) ? HMAX : h_cnt + HW'(1);
        cur_period = hs_ast ? period : h_total;
        height     = (hs_ast && (v_cnt != VMAX)) ? v_cnt + VW'(1) : v_cnt;
        nruns_eff  = vs_ast ? '0 : nruns;
        pos        = de_rise ? '0 : run_len;
        ypos       = de_rise ? nruns_eff : nruns_eff - VW'(1);
        cur_run    = de_fall ? run_len : last_run;
        run_bad    = de_fall && (run_len != HACT);
        x_over     = de1 && (pos > XMAX);
        y_over     = de1 && (ypos > YMAX);
        frame_good = runs_ok && !run_bad && (nruns == VACT);
        ref_match  = ref_ok && (cur_period == ref_period) && (height == ref_height) &&
                     (cur_run == ref_run) && (nruns == ref_runs);
        violation  = run_bad || (hs_ast && (period != ref_period)) ||
                     (vs_ast && ((nruns != VACT) || (height != ref_height))) ||
                     x_over || y_over;
    end

    // Input registers, measurement counters and pixel-coordinate outputs
    always_ff @(posedge clk_rgb) begin
        if (rst) begin
            {hs1, vs1, de1, hs1_q, vs1_q, de1_q} <= '0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            run_len     <= '0;
            last_run    <= '0;
            nruns       <= '0;
            runs_ok     <= 1'b0;
            vs_seen     <= 1'b0;
            h_total     <= '0;
            v_total     <= '0;
            x           <= '0;
            y           <= '0;
            valid       <= 1'b0;
            frame_start <= 1'b0;
        end else if (ce) begin
            hs1   <= hs;
            vs1   <= vs;
            de1   <= de;
            hs1_q <= hs1;
            vs1_q <= vs1;
            de1_q <= de1;

            h_cnt <= hs_ast ? '0 : period;
            if (hs_ast) h_total <= period;

            if (vs_ast)      v_cnt <= '0;
            else if (hs_ast) v_cnt <= height;
            if (vs_ast) v_total <= height;

            if (de1) run_len <= (pos == HMAX) ? HMAX : pos + HW'(1);
            if (de_fall) last_run <= run_len;

            if (de_rise)     nruns <= (nruns_eff == VMAX) ? VMAX : nruns_eff + VW'(1);
            else if (vs_ast) nruns <= '0;

            if (vs_ast)       runs_ok <= 1'b1;
            else if (run_bad) runs_ok <= 1'b0;
            if (vs_ast) vs_seen <= 1'b1;

            valid       <= de1;
            x           <= de1 ? XW'((pos > XMAX) ? XMAX : pos) : '0;
            y           <= de1 ? YW'((ypos > YMAX) ? YMAX : ypos) : '0;
            frame_start <= de_rise && (nruns_eff == '0) && (vs_seen || vs_ast);
        end
    end

    // Lock FSM: acquire on matching frames, drop with an err pulse on violation
    always_ff @(posedge clk_rgb) begin
        if (rst) begin
            state      <= SEARCH;
            locked     <= 1'b0;
            err        <= 1'b0;
            ref_ok     <= 1'b0;
            ref_period <= '0;
            ref_run    <= '0;
            ref_height <= '0;
            ref_runs   <= '0;
        end else if (ce) begin
            err <= 1'b0;
            case (state)
                SEARCH: begin
                    if (vs_ast) begin
                        state      <= TRACK;
                        ref_ok     <= 1'b0;
                        ref_period <= '0;
                        ref_run    <= '0;
                        ref_height <= '0;
                        ref_runs   <= '0;
                    end
                end
                TRACK: begin
                    if (vs_ast) begin
                        ref_ok     <= 1'b1;
                        ref_period <= cur_period;
                        ref_height <= height;
                        ref_run    <= cur_run;
                        ref_runs   <= nruns;
                        if (ref_match && frame_good) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (violation) begin
                        err    <= 1'b1;
                        locked <= 1'b0;
                        state  <= SEARCH;
                    end
                end
                default: begin
                    state  <= SEARCH;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_video_timing_decoder.sv
// Bench for video_timing_decoder on a scaled-down 8x4 raster (14x8 totals),
// with a frame-level reference model compared every cycle plus directed checks.
module tb_video_timing_decoder;
    localparam int HA   = 8;
    localparam int VA   = 4;
    localparam int MAXH = 31;
    localparam int MAXV = 15;
    localparam int HT   = 14;
    localparam int VT   = 8;

    logic       clk_rgb = 1'b0;
    logic       rst, ce, hs, vs, de;
    logic [2:0] x;
    logic [1:0] y;
    logic       valid, frame_start, locked, err;
    logic [4:0] h_total;
    logic [3:0] v_total;

    video_timing_decoder #(
        .HOR_ACTIVE_PIXELS(HA),
        .VER_ACTIVE_PIXELS(VA),
        .HOR_SYNC_POLARITY(0),
        .VER_SYNC_POLARITY(0),
        .MAX_HOR_TOTAL(MAXH),
        .MAX_VER_TOTAL(MAXV)
    ) dut (
        .clk_rgb(clk_rgb), .rst(rst), .ce(ce), .hs(hs), .vs(vs), .de(de),
        .x(x), .y(y), .valid(valid), .frame_start(frame_start),
        .locked(locked), .err(err), .h_total(h_total), .v_total(v_total)
    );

    always #5 clk_rgb = ~clk_rgb;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // ---------------- reference model (frame-level bookkeeping) ----------------
    typedef struct {
        int period;
        int height;
        int run;
        int cnt;
        bit good;
    } fsum_t;

    fsum_t hist[$];
    bit    model_on = 1'b0;
    bit    s_hs, s_vs, s_de, p_hs, p_vs, p_de;
    int    t, last_hs, hs_in_frame, rises, rise_t, last_run_m;
    bit    frame_bad, vs_seen, hunting, lk;
    int    e_x, e_y, e_ht, e_vt;
    bit    e_valid, e_fs, e_lk, e_err;

    function automatic void model_reset();
        model_on = 1'b1;
        {s_hs, s_vs, s_de, p_hs, p_vs, p_de} = '0;
        t = 0; last_hs = -1; hs_in_frame = 0; rises = 0; rise_t = 0; last_run_m = 0;
        frame_bad = 1'b1; vs_seen = 1'b0; hunting = 1'b1; lk = 1'b0;
        hist.delete();
        e_x = 0; e_y = 0; e_ht = 0; e_vt = 0;
        e_valid = 1'b0; e_fs = 1'b0; e_lk = 1'b0; e_err = 1'b0;
    endfunction

    function automatic void model_step(input bit ihs, input bit ivs, input bit ide);
        bit    hs_a, vs_a, rise, fall, viol;
        int    per, rl, hgt, cnt, xo, yo, n;
        fsum_t f;
        hs_a = (s_hs == 1'b0) && (p_hs != 1'b0);
        vs_a = (s_vs == 1'b0) && (p_vs != 1'b0);
        rise = s_de && !p_de;
        fall = !s_de && p_de;
        viol = 1'b0;
        e_fs = 1'b0;
        f = '{0, 0, 0, 0, 1'b0};
        if (hs_a) begin
            per = imin(t - last_hs, MAXH);
            e_ht = per; last_hs = t; hs_in_frame++;
            if (lk && per != hist[$].period) viol = 1'b1;
        end
        if (fall) begin
            rl = imin(t - rise_t, MAXH);
            last_run_m = rl;
            if (rl != HA) begin
                frame_bad = 1'b1;
                if (lk) viol = 1'b1;
            end
        end
        if (vs_a) begin
            hgt = imin(hs_in_frame, MAXV);
            cnt = imin(rises, MAXV);
            e_vt = hgt;
            if (lk && (cnt != VA || hgt != hist[$].height)) viol = 1'b1;
            f = '{e_ht, hgt, last_run_m, cnt, (!frame_bad && cnt == VA)};
            hs_in_frame = 0; rises = 0; frame_bad = 1'b0; vs_seen = 1'b1;
        end
        if (rise) begin
            e_fs = vs_seen && (rises == 0);
            rise_t = t; rises++;
        end
        e_valid = s_de;
        if (s_de) begin
            xo = t - rise_t;
            yo = rises - 1;
            if (lk && (xo > HA - 1 || yo > VA - 1)) viol = 1'b1;
            e_x = imin(xo, HA - 1);
            e_y = imin(yo, VA - 1);
        end else begin
            e_x = 0; e_y = 0;
        end
        e_err = viol;
        if (viol) begin
            lk = 1'b0; hunting = 1'b1; hist.delete();
        end else if (vs_a && !lk) begin
            if (hunting) begin
                hunting = 1'b0; hist.delete();
            end else begin
                hist.push_back(f);
                n = hist.size();
                if (n >= 2 && hist[n-1].period == hist[n-2].period &&
                    hist[n-1].height == hist[n-2].height && hist[n-1].run == hist[n-2].run &&
                    hist[n-1].cnt == hist[n-2].cnt && hist[n-1].good)
                    lk = 1'b1;
            end
        end
        e_lk = lk;
        p_hs = s_hs; p_vs = s_vs; p_de = s_de;
        s_hs = ihs;  s_vs = ivs;  s_de = ide;
        t++;
    endfunction

    always @(posedge clk_rgb) begin
        if (rst) model_reset();
        else if (ce && model_on) model_step(hs, vs, de);
    end

    // every-cycle comparison against the model
    always @(negedge clk_rgb) begin
        if (model_on) begin
            chk("x", int'(x), e_x);
            chk("y", int'(y), e_y);
            chk("valid", int'(valid), int'(e_valid));
            chk("frame_start", int'(frame_start), int'(e_fs));
            chk("locked", int'(locked), int'(e_lk));
            chk("err", int'(err), int'(e_err));
            chk("h_total", int'(h_total), e_ht);
            chk("v_total", int'(v_total), e_vt);
        end
    end

    // ---------------- stream driver ----------------
    int hp = 4, vp = VT - 1;
    int vs_cnt = 0;
    bit toggle_ce = 1'b0;
    bit cut_de = 1'b0;
    int st_valid, st_fs, st_fx, st_fy, st_lx, st_ly;

    task automatic pix();
        logic h_s, v_s, d_s;
        h_s = (hp >= 2);
        v_s = (vp >= 1);
        d_s = (hp >= 4) && (hp < 4 + HA) && (vp >= 2) && (vp < 2 + VA);
        if (cut_de && vp == 3 && hp == 11) begin
            d_s = 1'b0;
            cut_de = 1'b0;
        end
        if (hp == 0 && vp == 0) vs_cnt++;
        hs = h_s; vs = v_s; de = d_s; ce = 1'b1;
        @(posedge clk_rgb); #1;
        if (valid) begin st_valid++; st_lx = int'(x); st_ly = int'(y); end
        if (frame_start) begin st_fs++; st_fx = int'(x); st_fy = int'(y); end
        hp++;
        if (hp == HT) begin hp = 0; vp = (vp + 1) % VT; end
        if (toggle_ce) begin
            ce = 1'b0; hs = 1'($urandom); vs = 1'($urandom); de = 1'($urandom);
            @(posedge clk_rgb); #1;
        end
    endtask

    task automatic goto_pos(input int v, input int h);
        for (int i = 0; i < 400 && !(vp == v && hp == h); i++) pix();
    endtask

    task automatic reset_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            rst = 1'b1; ce = 1'($urandom);
            hs = 1'($urandom); vs = 1'($urandom); de = 1'($urandom);
            @(posedge clk_rgb); #1;
        end
        rst = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_x"}, int'(x), 0);
        chk({tag, "_y"}, int'(y), 0);
        chk({tag, "_valid"}, int'(valid), 0);
        chk({tag, "_fs"}, int'(frame_start), 0);
        chk({tag, "_locked"}, int'(locked), 0);
        chk({tag, "_err"}, int'(err), 0);
        chk({tag, "_htot"}, int'(h_total), 0);
        chk({tag, "_vtot"}, int'(v_total), 0);
    endtask

    // locked must rise exactly on the ce-cycle after the one carrying the 3rd vs assert
    task automatic expect_lock(input string tag);
        vs_cnt = 0;
        for (int i = 0; i < 2000 && vs_cnt < 3; i++) pix();
        chk({tag, "_prelock"}, int'(locked), 0);
        pix();
        chk({tag, "_lock"}, int'(locked), 1);
        chk({tag, "_htot"}, int'(h_total), HT);
        chk({tag, "_vtot"}, int'(v_total), VT);
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; hs = 1'b1; vs = 1'b1; de = 1'b0;

        // 1: reset with random inputs
        reset_cycles(3);
        check_zero("reset");

        // 2: lock on a clean stream
        expect_lock("lock1");

        // 3: one whole locked frame
        goto_pos(0, 0);
        st_valid = 0; st_fs = 0; st_fx = -1; st_fy = -1; st_lx = -1; st_ly = -1;
        for (int i = 0; i < HT * VT; i++) pix();
        chk("frame_valid_count", st_valid, HA * VA);
        chk("frame_start_count", st_fs, 1);
        chk("frame_start_x", st_fx, 0);
        chk("frame_start_y", st_fy, 0);
        chk("last_pixel_x", st_lx, HA - 1);
        chk("last_pixel_y", st_ly, VA - 1);

        // 4: one short de run while locked
        goto_pos(3, 11);
        cut_de = 1'b1;
        pix();
        chk("cut_err_early", int'(err), 0);
        pix();
        chk("cut_err", int'(err), 1);
        chk("cut_unlock", int'(locked), 0);
        pix();
        chk("cut_err_width", int'(err), 0);
        expect_lock("relock");

        // 5: ce toggling 1/0 with garbage on the idle cycles
        reset_cycles(1);
        toggle_ce = 1'b1;
        expect_lock("ce_toggle");
        toggle_ce = 1'b0;

        // 6: reset mid-frame while locked
        goto_pos(3, 6);
        chk("midrst_locked_before", int'(locked), 1);
        reset_cycles(1);
        check_zero("midrst");
        expect_lock("midrst_relock");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
